// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: four-way round-robin arbiter feeding one UART transmitter.
// Each grant latches the winner's byte and strobes tx_send_o for one bit time.
// The arbiter then stays busy for the rest of the frame plus an idle gap, and
// only after that does it return to arbitration.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   en_i        grant enable; a frame already in progress always completes
//   req_i       per-requester transmit request, held until the matching ack
//   req_data_i  byte for requester i on bits [8i+7:8i]
//   ack_o       one-cycle pulse to the requester whose byte was latched
//   tx_send_o   send strobe to the UART transmitter, high for one bit time
//   tx_data_o   byte presented to the UART transmitter
//   busy_o      high while a frame or its trailing gap is in progress
//   grant_id_o  index of the most recently granted requester
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter int unsigned FRAME_BITS   = 11,
  parameter int unsigned GAP_CLKS     = 2604
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [3:0]  req_i,
  input  logic [31:0] req_data_i,
  output logic [3:0]  ack_o,
  output logic        tx_send_o,
  output logic [7:0]  tx_data_o,
  output logic        busy_o,
  output logic [1:0]  grant_id_o
);

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CNT_W   = 16;

  // Counter reload values; each state leaves when its counter reaches zero.
  localparam logic [CNT_W-1:0] SEND_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    CNT_W'((FRAME_BITS - 1) * CLKS_PER_BIT + GAP_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             arm_q;
  logic [3:0]       ack_q, ack_d;
  logic             tx_send_q, tx_send_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic [1:0]       grant_id_q, grant_id_d;

  logic             win_valid;
  logic [1:0]       win_idx;
  logic [7:0]       win_byte;

  // Round-robin search starting one past the last winner.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!win_valid && req_i[2'(ptr_q + 2'(k))]) begin
        win_valid = 1'b1;
        win_idx   = 2'(ptr_q + 2'(k));
      end
    end
  end

  assign win_byte = req_data_i[{win_idx, 3'b000} +: 8];

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ptr_q      <= 2'd3;
      arm_q      <= 1'b0;
      ack_q      <= '0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      grant_id_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      arm_q      <= 1'b1;
      ack_q      <= ack_d;
      tx_send_q  <= tx_send_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Next-state logic. arm_q blocks a grant on the first edge after reset
  // release so a frame cut short by reset is never reissued immediately.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    ack_d      = '0;
    tx_send_d  = tx_send_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_send_d = 1'b0;
        if (en_i && arm_q && win_valid) begin
          state_d          = ST_SEND;
          cnt_d            = SEND_LOAD;
          ptr_d            = win_idx;
          grant_id_d       = win_idx;
          tx_data_d        = win_byte;
          ack_d[win_idx]   = 1'b1;
          tx_send_d        = 1'b1;
        end
      end
      ST_SEND: begin
        if (cnt_q == '0) begin
          state_d   = ST_WAIT;
          cnt_d     = WAIT_LOAD;
          tx_send_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        tx_send_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        tx_send_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign ack_o      = ack_q;
  assign tx_send_o  = tx_send_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = busy_q;
  assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. A transaction-level model predicts the
// outputs from grant times: a grant is legal when the block is armed and
// enabled, a request is pending, and at least SPACING edges have passed
// since the previous grant. All outputs then follow from the offset to that
// grant.
module tb_uart_tx_arbiter;

  localparam int CPB      = 4;
  localparam int FB       = 11;
  localparam int GAP      = 2;
  localparam int SPACING  = FB * CPB + GAP + 1;
  localparam int BUSY_LEN = SPACING - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack_o;
  logic        tx_send_o;
  logic [7:0]  tx_data_o;
  logic        busy_o;
  logic [1:0]  grant_id_o;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .CLKS_PER_BIT (CPB),
    .FRAME_BITS   (FB),
    .GAP_CLKS     (GAP)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .req_i      (req),
    .req_data_i (req_data),
    .ack_o      (ack_o),
    .tx_send_o  (tx_send_o),
    .tx_data_o  (tx_data_o),
    .busy_o     (busy_o),
    .grant_id_o (grant_id_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // Reference model state
  bit         m_has;
  bit         m_armed;
  int         m_g;
  int         m_ptr;
  logic [7:0] m_data;
  logic [1:0] m_gid;
  logic [3:0] exp_ack;
  logic       exp_tx;
  logic       exp_busy;

  // Advance one clock: update the model from the inputs seen at the edge,
  // then sample just after the edge.
  task automatic step();
    int w;
    int d;
    w = -1;
    edge_n++;
    if (m_armed && en && req != 4'b0000 && (!m_has || edge_n - m_g >= SPACING)) begin
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (w < 0 && req[i]) w = i;
      end
      m_has  = 1'b1;
      m_g    = edge_n;
      m_ptr  = w;
      m_gid  = 2'(w);
      m_data = req_data[8*w +: 8];
    end
    m_armed = 1'b1;
    @(posedge clk);
    #1;
    d        = edge_n - m_g;
    exp_busy = m_has && (d < BUSY_LEN);
    exp_tx   = m_has && (d < CPB);
    exp_ack  = (m_has && d == 0) ? (4'b0001 << m_gid) : 4'b0000;
  endtask

  task automatic assert_rst();
    rst_n   = 1'b0;
    m_has   = 1'b0;
    m_armed = 1'b0;
    m_ptr   = 3;
    m_data  = 8'h00;
    m_gid   = 2'd0;
    exp_ack = 4'b0000;
    exp_tx  = 1'b0;
    exp_busy = 1'b0;
    #1;
  endtask

  task automatic release_rst();
    repeat (2) begin
      @(posedge clk);
      edge_n++;
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    en       = 1'b0;
    req      = 4'b0000;
    req_data = 32'h0;
    #1;
    assert_rst();
    n_tests++;
    if ({ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_values: got ack=%b tx=%b busy=%b data=%h gid=%0d want all zero",
               ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o);
    end
    release_rst();
    repeat (2) begin
      step();
      n_tests++;
      if ({ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o} !== {exp_ack, exp_tx, exp_busy, m_data, m_gid}) begin
        n_fail++;
        $display("FAIL reset_idle edge %0d: got ack=%b tx=%b busy=%b data=%h gid=%0d want ack=%b tx=%b busy=%b data=%h gid=%0d",
                 edge_n, ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o, exp_ack, exp_tx, exp_busy, m_data, m_gid);
      end
    end
  endtask

  task automatic test_single();
    int n_tx, n_busy;
    n_tx = 0; n_busy = 0;
    en = 1'b1;
    req_data = 32'h0000_00CD;
    req = 4'b0001;
    for (int c = 0; c < 60; c++) begin
      step();
      n_tests++;
      if ({ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o} !== {exp_ack, exp_tx, exp_busy, m_data, m_gid}) begin
        n_fail++;
        $display("FAIL single edge %0d: got ack=%b tx=%b busy=%b data=%h gid=%0d want ack=%b tx=%b busy=%b data=%h gid=%0d",
                 edge_n, ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o, exp_ack, exp_tx, exp_busy, m_data, m_gid);
      end
      if (c == 0) begin
        n_tests++;
        if (ack_o !== 4'b0001 || tx_data_o !== 8'hCD) begin
          n_fail++;
          $display("FAIL single_first: got ack=%b data=%h want ack=0001 data=cd", ack_o, tx_data_o);
        end
      end
      if (tx_send_o === 1'b1) n_tx++;
      if (busy_o === 1'b1) n_busy++;
      req &= ~exp_ack;
    end
    n_tests++;
    if (n_tx != CPB || n_busy != BUSY_LEN) begin
      n_fail++;
      $display("FAIL single_lengths: got tx=%0d busy=%0d want tx=%0d busy=%0d", n_tx, n_busy, CPB, BUSY_LEN);
    end
  endtask

  task automatic test_round_robin();
    int g_idx[$];
    int g_cyc[$];
    logic [7:0] g_dat[$];
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    assert_rst();
    release_rst();
    req_data = 32'h4433_2211;
    req = 4'b1111;
    for (int c = 0; c < 200; c++) begin
      step();
      n_tests++;
      if ({ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o} !== {exp_ack, exp_tx, exp_busy, m_data, m_gid}) begin
        n_fail++;
        $display("FAIL round_robin edge %0d: got ack=%b tx=%b busy=%b data=%h gid=%0d want ack=%b tx=%b busy=%b data=%h gid=%0d",
                 edge_n, ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o, exp_ack, exp_tx, exp_busy, m_data, m_gid);
      end
      if (ack_o !== 4'b0000) begin
        g_idx.push_back(ack_o[1] ? 1 : ack_o[2] ? 2 : ack_o[3] ? 3 : 0);
        g_cyc.push_back(c);
        g_dat.push_back(tx_data_o);
      end
    end
    n_tests++;
    if (g_idx.size() != 5) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants want 5", g_idx.size());
    end
    for (int i = 0; i < g_idx.size() && i < 5; i++) begin
      n_tests++;
      if (g_idx[i] != exp_order[i] || g_dat[i] !== 8'(8'h11 * (exp_order[i] + 1)) ||
          (i > 0 && g_cyc[i] - g_cyc[i-1] != SPACING)) begin
        n_fail++;
        $display("FAIL rr_grant %0d: got id=%0d data=%h cyc=%0d want id=%0d data=%h spacing=%0d",
                 i, g_idx[i], g_dat[i], g_cyc[i], exp_order[i], 8'(8'h11 * (exp_order[i] + 1)), SPACING);
      end
    end
  endtask

  task automatic test_wait_ignore();
    int first_d;
    logic [3:0] first_ack;
    bit granted;
    first_d = -1; first_ack = 4'b0000; granted = 1'b0;
    req = 4'b0000;
    for (int c = 0; c < 50; c++) begin
      step();
      n_tests++;
      if ({ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o} !== {exp_ack, exp_tx, exp_busy, m_data, m_gid}) begin
        n_fail++;
        $display("FAIL drain edge %0d: got ack=%b tx=%b busy=%b want ack=%b tx=%b busy=%b",
                 edge_n, ack_o, tx_send_o, busy_o, exp_ack, exp_tx, exp_busy);
      end
    end
    req_data = 32'h00A7_005A;
    req = 4'b0001;
    for (int c = 0; c < 5 && !granted; c++) begin
      step();
      granted = (exp_ack != 4'b0000);
      req &= ~exp_ack;
    end
    n_tests++;
    if (!granted || ack_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL wait_first_grant: got ack=%b want ack=0001 within 5 cycles", ack_o);
    end
    for (int d = 1; d <= 60; d++) begin
      if (d == 10) req = 4'b0100;
      step();
      n_tests++;
      if ({ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o} !== {exp_ack, exp_tx, exp_busy, m_data, m_gid}) begin
        n_fail++;
        $display("FAIL wait_ignore edge %0d: got ack=%b tx=%b busy=%b data=%h gid=%0d want ack=%b tx=%b busy=%b data=%h gid=%0d",
                 edge_n, ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o, exp_ack, exp_tx, exp_busy, m_data, m_gid);
      end
      if (ack_o !== 4'b0000 && first_d < 0) begin
        first_d = d;
        first_ack = ack_o;
      end
      req &= ~exp_ack;
    end
    n_tests++;
    if (first_d != SPACING || first_ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL wait_next_ack: got ack=%b at offset %0d want ack=0100 at offset %0d", first_ack, first_d, SPACING);
    end
  endtask

  task automatic test_enable();
    int bad;
    bad = 0;
    en = 1'b0;
    req_data = 32'h0000_3C00;
    req = 4'b0010;
    for (int c = 0; c < 100; c++) begin
      step();
      n_tests++;
      if ({ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o} !== {exp_ack, exp_tx, exp_busy, m_data, m_gid}) begin
        n_fail++;
        $display("FAIL enable_low edge %0d: got ack=%b tx=%b busy=%b want ack=%b tx=%b busy=%b",
                 edge_n, ack_o, tx_send_o, busy_o, exp_ack, exp_tx, exp_busy);
      end
      if (ack_o !== 4'b0000 || tx_send_o !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL enable_blocked: got %0d cycles with ack/tx_send want 0", bad);
    end
    en = 1'b1;
    step();
    n_tests++;
    if (ack_o !== 4'b0010 || tx_data_o !== 8'h3C || exp_ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL enable_grant: got ack=%b data=%h want ack=0010 data=3c", ack_o, tx_data_o);
    end
    req &= ~exp_ack;
  endtask

  task automatic test_reset_mid();
    bit granted;
    granted = 1'b0;
    req = 4'b0000;
    repeat (50) step();
    req_data = 32'hE100_0096;
    req = 4'b0001;
    for (int c = 0; c < 5 && !granted; c++) begin
      step();
      granted = (exp_ack != 4'b0000);
      req &= ~exp_ack;
    end
    step();
    n_tests++;
    if (!granted || tx_send_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: got tx=%b busy=%b want tx=1 busy=1 in SEND", tx_send_o, busy_o);
    end
    assert_rst();
    n_tests++;
    if ({ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o} !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_reset: got ack=%b tx=%b busy=%b data=%h gid=%0d want all zero",
               ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o);
    end
    req = 4'b1001;
    release_rst();
    step();
    n_tests++;
    if (ack_o !== 4'b0000 || tx_send_o !== 1'b0 || exp_ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_release_hold: got ack=%b tx=%b want ack=0000 tx=0", ack_o, tx_send_o);
    end
    step();
    n_tests++;
    if (ack_o !== 4'b0001 || tx_data_o !== 8'h96 || exp_ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_first_grant: got ack=%b data=%h want ack=0001 data=96", ack_o, tx_data_o);
    end
    req &= ~exp_ack;
  endtask

  task automatic test_pulse();
    int n_ack;
    n_ack = 0;
    repeat (5) step();
    req_data = 32'h0000_7700;
    req = 4'b0010;
    step();
    if (ack_o !== 4'b0000) n_ack++;
    req = 4'b0000;
    for (int c = 0; c < 60; c++) begin
      step();
      n_tests++;
      if ({ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o} !== {exp_ack, exp_tx, exp_busy, m_data, m_gid}) begin
        n_fail++;
        $display("FAIL pulse edge %0d: got ack=%b tx=%b busy=%b want ack=%b tx=%b busy=%b",
                 edge_n, ack_o, tx_send_o, busy_o, exp_ack, exp_tx, exp_busy);
      end
      if (ack_o !== 4'b0000) n_ack++;
    end
    n_tests++;
    if (n_ack != 0) begin
      n_fail++;
      $display("FAIL pulse_no_ack: got %0d acks want 0", n_ack);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 7) == 0) begin
          req_data[8*i +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
      step();
      n_tests++;
      if ({ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o} !== {exp_ack, exp_tx, exp_busy, m_data, m_gid}) begin
        n_fail++;
        $display("FAIL random edge %0d: got ack=%b tx=%b busy=%b data=%h gid=%0d want ack=%b tx=%b busy=%b data=%h gid=%0d",
                 edge_n, ack_o, tx_send_o, busy_o, tx_data_o, grant_id_o, exp_ack, exp_tx, exp_busy, m_data, m_gid);
      end
      req &= ~exp_ack;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wait_ignore();
    test_enable();
    test_reset_mid();
    test_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 2604, giving clocks per UART bit (25 MHz clk, 9600 baud).
REQ-002 The block SHALL have parameter FRAME_BITS, default 11, giving bits per frame (start + 8 data + parity + stop).
REQ-003 The block SHALL have parameter GAP_CLKS, default 2604, giving idle clocks enforced after each frame.
REQ-004 clk  input  1  single system clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  grant enable; low blocks new grants, and a frame in progress still completes.
REQ-007 req  input  4  per-requester transmit request; held high until the matching ack.
REQ-008 req_data  input  32  byte for requester i on bits [8i+7:8i]; stable while req[i] is high.
REQ-009 ack  output  4  one-cycle pulse to the granted requester when its byte is latched.
REQ-010 tx_send  output  1  send strobe to the UART transmitter.
REQ-011 Tx_data  output  8  byte presented to the UART transmitter.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 grant_id  output  2  index of the most recently granted requester.

Function
REQ-014 The FSM SHALL have states IDLE, SEND and WAIT, plus a 16-bit cycle counter and a 2-bit round-robin pointer ptr.
REQ-015 IDLE: on an edge with en=1 and req!=0, the block SHALL grant the first requester with req high, searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-016 On that same edge it SHALL latch the granted byte into Tx_data, set grant_id and ptr to the winner, drive ack[winner]=1, set tx_send=1 and enter SEND.
REQ-017 ack SHALL be high for exactly one cycle per grant, and at most one ack bit SHALL be high in any cycle.
REQ-018 Latency: tx_send and ack SHALL rise one clock after the edge at which req is first sampled high in IDLE.
REQ-019 SEND: tx_send SHALL stay high for exactly CLKS_PER_BIT cycles, then drop as the FSM enters WAIT.
REQ-020 WAIT: the FSM SHALL stay for (FRAME_BITS-1)*CLKS_PER_BIT + GAP_CLKS cycles, then return to IDLE.
REQ-021 Grant-to-grant spacing under continuous requests SHALL be exactly FRAME_BITS*CLKS_PER_BIT + GAP_CLKS + 1 cycles.
REQ-022 Tx_data and grant_id SHALL hold their values until the next grant.
REQ-023 In SEND and WAIT, req changes SHALL be ignored and no ack SHALL issue.
REQ-024 A req dropped before its ack SHALL be forgotten, with no state change.
REQ-025 en falling during SEND or WAIT SHALL not shorten the frame; the FSM SHALL then stay in IDLE until en=1.
REQ-026 The counter SHALL count down and reload on each state entry; it SHALL never wrap, and parameters SHALL satisfy FRAME_BITS*CLKS_PER_BIT+GAP_CLKS < 65536.
REQ-027 With a single persistent requester, that requester SHALL be re-granted every spacing period.

Reset
REQ-028 rst=0 SHALL immediately, without a clock, force state=IDLE, tx_send=0, Tx_data=8'h00, ack=4'b0000, busy=0, grant_id=0, ptr=3 and counter=0.
REQ-029 Because ptr resets to 3, requester 0 SHALL have first priority after reset.
REQ-030 A reset mid-frame SHALL truncate the strobe and grant no requester on release.
REQ-031 The first grant after rst rises SHALL occur no earlier than the second rising edge after release.

Verification (bench overrides CLKS_PER_BIT=4, GAP_CLKS=2, so spacing is 47)
REQ-032 req=4'b0001, byte0=8'hCD, en=1 -> one cycle later ack=0001, tx_send=1 for 4 cycles, Tx_data=CD, busy=1 for 46 cycles.
REQ-033 req=4'b1111 held, bytes 11/22/33/44 -> grants in order 0,1,2,3,0 at 47-cycle spacing, with Tx_data matching each grant.
REQ-034 req=4'b0100 raised during WAIT of a requester-0 frame -> no ack until IDLE; then ack=0100 exactly one cycle after IDLE entry.
REQ-035 en=0 with req=4'b0010 -> no ack or tx_send for 100 cycles; en=1 -> ack=0010 on the next cycle.
REQ-036 rst=0 in cycle 2 of SEND -> tx_send=0 and busy=0 immediately; after release with req=4'b1001 -> requester 0 granted first.
REQ-037 req[1] pulsed for 1 cycle while busy -> never acked; ack=0000 throughout.
